// File: rtl/clks_alot_lock_tracker_pkg.sv
// Shared types for the clks_alot lock tracker: FSM states, shared config and per-channel status.
package clks_alot_p;

    localparam int COUNTER_WIDTH = 16;

    typedef enum logic [2:0] {
        LK_IDLE,
        LK_ACQUIRE,
        LK_LOCKED,
        LK_PAUSED,
        LK_FAULT
    } lock_state_e;

    typedef struct packed {
        logic [COUNTER_WIDTH-1:0] expected_period;
        logic [COUNTER_WIDTH-1:0] tolerance;
        logic [COUNTER_WIDTH-1:0] pause_timeout;
    } lock_cfg_s;

    typedef struct packed {
        logic locked;
        logic pause_active;
        logic over_viol;
        logic under_viol;
        logic stall_fault;
    } lock_status_s;

endpackage

// File: rtl/clks_alot_lock_chan.sv
// Single-channel lock/pause FSM with period counter and tolerance check.
// Optional min/max/violation statistics when CLKS_ALOT_LOCK_STATS_EN is defined.
module clks_alot_lock_chan
    import clks_alot_p::*;
#(
    parameter int LOCK_COUNT    = 8,
    parameter int UNLOCK_MISSES = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     en_i,
    input  logic                     clear_i,
    input  logic                     edge_i,
    input  logic                     pausable_i,
    input  lock_cfg_s                cfg_i,
    output lock_status_s             status_o,
    output logic [COUNTER_WIDTH-1:0] pause_duration_o,
    output logic [COUNTER_WIDTH-1:0] period_o
`ifdef CLKS_ALOT_LOCK_STATS_EN
    ,
    output logic [COUNTER_WIDTH-1:0] period_min_o,
    output logic [COUNTER_WIDTH-1:0] period_max_o,
    output logic [15:0]              viol_count_o
`endif
);
    localparam int CW = COUNTER_WIDTH;
    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam int MW = $clog2(UNLOCK_MISSES + 1);

    lock_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, period_q, pdur_q;
    logic [GW-1:0] good_q;
    logic [MW-1:0] miss_q;
    logic          resume_q, over_q, under_q, stall_q;
    logic [CW:0]   hi, lo, meas;
    logic          kill, active, measured, over, under, good, timeout;

    assign kill     = !en_i || clear_i;
    assign active   = (state_q == LK_ACQUIRE) || (state_q == LK_LOCKED);
    // One extra bit so expected+tol cannot wrap; lower bound clamps at zero.
    assign hi       = {1'b0, cfg_i.expected_period} + {1'b0, cfg_i.tolerance};
    assign lo       = (cfg_i.tolerance > cfg_i.expected_period) ? '0
                    : {1'b0, cfg_i.expected_period} - {1'b0, cfg_i.tolerance};
    assign meas     = {1'b0, cnt_q};
    assign over     = meas > hi;
    assign under    = meas < lo;
    assign good     = !over && !under;
    assign measured = edge_i && active;
    assign timeout  = !edge_i && active && (cnt_q > cfg_i.pause_timeout);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= LK_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (kill) begin
            state_d = LK_IDLE;
        end else begin
            unique case (state_q)
                LK_IDLE:    if (edge_i) state_d = LK_ACQUIRE;
                LK_ACQUIRE: begin
                    if (measured && good && good_q == GW'(LOCK_COUNT - 1)) state_d = LK_LOCKED;
                    else if (timeout) state_d = pausable_i ? LK_PAUSED : LK_FAULT;
                end
                LK_LOCKED: begin
                    if (measured && !good && miss_q == MW'(UNLOCK_MISSES - 1)) state_d = LK_ACQUIRE;
                    else if (timeout) state_d = pausable_i ? LK_PAUSED : LK_FAULT;
                end
                LK_PAUSED:  if (edge_i) state_d = resume_q ? LK_LOCKED : LK_ACQUIRE;
                LK_FAULT:   state_d = LK_FAULT;
                default:    state_d = LK_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q    <= '0;
            period_q <= '0;
            pdur_q   <= '0;
            good_q   <= '0;
            miss_q   <= '0;
            resume_q <= 1'b0;
            over_q   <= 1'b0;
            under_q  <= 1'b0;
            stall_q  <= 1'b0;
        end else if (kill) begin
            cnt_q    <= '0;
            period_q <= '0;
            pdur_q   <= '0;
            good_q   <= '0;
            miss_q   <= '0;
            resume_q <= 1'b0;
            over_q   <= 1'b0;
            under_q  <= 1'b0;
            stall_q  <= 1'b0;
        end else begin
            cnt_q   <= edge_i ? CW'(1) : cnt_q + CW'(!(&cnt_q));
            over_q  <= measured && over;
            under_q <= measured && under;
            if (measured)              period_q <= cnt_q;
            if (state_q == LK_PAUSED)  pdur_q   <= cnt_q;
            // Remember where a pause came from; frozen while paused.
            if (state_q != LK_PAUSED)  resume_q <= (state_q == LK_LOCKED);
            if (state_d == LK_FAULT)   stall_q  <= 1'b1;
            if (state_q == LK_IDLE) begin
                good_q <= '0;
                miss_q <= '0;
            end else if (measured && state_q == LK_ACQUIRE) begin
                good_q <= good ? good_q + GW'(1) : '0;
                miss_q <= '0;
            end else if (measured) begin
                if (good) begin
                    miss_q <= '0;
                end else if (miss_q == MW'(UNLOCK_MISSES - 1)) begin
                    miss_q <= '0;
                    good_q <= '0;
                end else begin
                    miss_q <= miss_q + MW'(1);
                end
            end
        end
    end

    always_comb begin
        status_o              = '0;
        status_o.locked       = (state_q == LK_LOCKED);
        status_o.pause_active = (state_q == LK_PAUSED);
        status_o.over_viol    = over_q;
        status_o.under_viol   = under_q;
        status_o.stall_fault  = stall_q;
    end

    assign pause_duration_o = pdur_q;
    assign period_o         = period_q;

`ifdef CLKS_ALOT_LOCK_STATS_EN
    logic [CW-1:0] min_q, max_q;
    logic [15:0]   viol_q;
    logic          seen_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            min_q  <= '0;
            max_q  <= '0;
            viol_q <= '0;
            seen_q <= 1'b0;
        end else if (kill) begin
            min_q  <= '0;
            max_q  <= '0;
            viol_q <= '0;
            seen_q <= 1'b0;
        end else if (measured) begin
            seen_q <= 1'b1;
            if (!seen_q || cnt_q < min_q) min_q <= cnt_q;
            if (!seen_q || cnt_q > max_q) max_q <= cnt_q;
            if (!good && !(&viol_q))      viol_q <= viol_q + 16'd1;
        end
    end

    assign period_min_o = min_q;
    assign period_max_o = max_q;
    assign viol_count_o = viol_q;
`endif

endmodule

// File: rtl/clks_alot_lock_tracker.sv
// Multi-channel lock/pause tracker: one clks_alot_lock_chan per channel, shared config.
// Optional statistics ports appear when CLKS_ALOT_LOCK_STATS_EN is defined.
module clks_alot_lock_tracker
    import clks_alot_p::*;
#(
    parameter int CHANNELS      = 4,
    parameter int COUNTER_WIDTH = clks_alot_p::COUNTER_WIDTH,
    parameter int LOCK_COUNT    = 8,
    parameter int UNLOCK_MISSES = 2
) (
    input  logic                                    clk_i,
    input  logic                                    rst_n_i,
    input  logic [CHANNELS-1:0]                     en_i,
    input  logic [CHANNELS-1:0]                     clear_i,
    input  logic [CHANNELS-1:0]                     edge_i,
    input  logic [CHANNELS-1:0]                     pausable_i,
    input  logic [COUNTER_WIDTH-1:0]                expected_period_i,
    input  logic [COUNTER_WIDTH-1:0]                tolerance_i,
    input  logic [COUNTER_WIDTH-1:0]                pause_timeout_i,
    output logic [CHANNELS-1:0]                     locked_o,
    output logic [CHANNELS-1:0]                     pause_active_o,
    output logic [CHANNELS-1:0][COUNTER_WIDTH-1:0]  pause_duration_o,
    output logic [CHANNELS-1:0][COUNTER_WIDTH-1:0]  period_o,
    output logic [CHANNELS-1:0]                     over_viol_o,
    output logic [CHANNELS-1:0]                     under_viol_o,
    output logic [CHANNELS-1:0]                     stall_fault_o
`ifdef CLKS_ALOT_LOCK_STATS_EN
    ,
    output logic [CHANNELS-1:0][COUNTER_WIDTH-1:0]  period_min_o,
    output logic [CHANNELS-1:0][COUNTER_WIDTH-1:0]  period_max_o,
    output logic [CHANNELS-1:0][15:0]               viol_count_o
`endif
);
    // The config struct is sized by the package width; COUNTER_WIDTH must track it.
    lock_cfg_s                   cfg;
    lock_status_s [CHANNELS-1:0] st;

    assign cfg.expected_period = expected_period_i;
    assign cfg.tolerance       = tolerance_i;
    assign cfg.pause_timeout   = pause_timeout_i;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        clks_alot_lock_chan #(
            .LOCK_COUNT    (LOCK_COUNT),
            .UNLOCK_MISSES (UNLOCK_MISSES)
        ) u_chan (
            .clk_i            (clk_i),
            .rst_n_i          (rst_n_i),
            .en_i             (en_i[g]),
            .clear_i          (clear_i[g]),
            .edge_i           (edge_i[g]),
            .pausable_i       (pausable_i[g]),
            .cfg_i            (cfg),
            .status_o         (st[g]),
            .pause_duration_o (pause_duration_o[g]),
            .period_o         (period_o[g])
`ifdef CLKS_ALOT_LOCK_STATS_EN
            ,
            .period_min_o     (period_min_o[g]),
            .period_max_o     (period_max_o[g]),
            .viol_count_o     (viol_count_o[g])
`endif
        );

        assign locked_o[g]       = st[g].locked;
        assign pause_active_o[g] = st[g].pause_active;
        assign over_viol_o[g]    = st[g].over_viol;
        assign under_viol_o[g]   = st[g].under_viol;
        assign stall_fault_o[g]  = st[g].stall_fault;
    end

endmodule

// File: tb/tb_clks_alot_lock_tracker.sv
// Bench for clks_alot_lock_tracker: directed edge patterns, a cycle model and literal spot checks.
module tb_clks_alot_lock_tracker;
    import clks_alot_p::*;

    localparam int CH = 4;
    localparam int CW = COUNTER_WIDTH;
    localparam int LC = 8;
    localparam int UM = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [CH-1:0] en, clr, edg, pausable;
    logic [CW-1:0] exp_p, tol, pto;
    logic [CH-1:0] locked, pact, ov, un, stall;
    logic [CH-1:0][CW-1:0] pdur, period;
`ifdef CLKS_ALOT_LOCK_STATS_EN
    logic [CH-1:0][CW-1:0] pmin, pmax;
    logic [CH-1:0][15:0]   vcnt;
`endif

    always #5 clk = ~clk;

    clks_alot_lock_tracker #(.CHANNELS(CH), .LOCK_COUNT(LC), .UNLOCK_MISSES(UM)) dut (
        .clk_i             (clk),
        .rst_n_i           (rst_n),
        .en_i              (en),
        .clear_i           (clr),
        .edge_i            (edg),
        .pausable_i        (pausable),
        .expected_period_i (exp_p),
        .tolerance_i       (tol),
        .pause_timeout_i   (pto),
        .locked_o          (locked),
        .pause_active_o    (pact),
        .pause_duration_o  (pdur),
        .period_o          (period),
        .over_viol_o       (ov),
        .under_viol_o      (un),
        .stall_fault_o     (stall)
`ifdef CLKS_ALOT_LOCK_STATS_EN
        ,
        .period_min_o      (pmin),
        .period_max_o      (pmax),
        .viol_count_o      (vcnt)
`endif
    );

    int checks = 0;
    int errors = 0;
    int nprint = 0;

    // Model: mode 0 idle, 1 acquiring, 2 locked, 3 paused, 4 faulted.
    int m_mode[CH]   = '{default: 0};
    int m_since[CH]  = '{default: 0};
    int m_good[CH]   = '{default: 0};
    int m_miss[CH]   = '{default: 0};
    int m_from[CH]   = '{default: 0};
    int m_period[CH] = '{default: 0};
    int m_pdur[CH]   = '{default: 0};
    int m_over[CH]   = '{default: 0};
    int m_under[CH]  = '{default: 0};
    int m_stall[CH]  = '{default: 0};

    function automatic void mreset(int c);
        m_mode[c] = 0; m_since[c] = 0; m_good[c] = 0; m_miss[c] = 0; m_from[c] = 0;
        m_period[c] = 0; m_pdur[c] = 0; m_over[c] = 0; m_under[c] = 0; m_stall[c] = 0;
    endfunction

    function automatic void step(int c);
        int s;
        bit e, ov_b, un_b, ok;
        s = m_since[c];
        e = edg[c];
        if (!en[c] || clr[c]) begin
            mreset(c);
            return;
        end
        m_over[c] = 0;
        m_under[c] = 0;
        if (e && (m_mode[c] == 1 || m_mode[c] == 2)) begin
            ov_b = s > int'(exp_p) + int'(tol);
            un_b = s < int'(exp_p) - int'(tol);
            ok = !ov_b && !un_b;
            m_period[c] = s;
            m_over[c] = ov_b;
            m_under[c] = un_b;
            if (m_mode[c] == 1) begin
                if (ok) begin
                    m_good[c]++;
                    if (m_good[c] == LC) begin m_mode[c] = 2; m_miss[c] = 0; end
                end else m_good[c] = 0;
            end else begin
                if (ok) m_miss[c] = 0;
                else begin
                    m_miss[c]++;
                    if (m_miss[c] == UM) begin m_mode[c] = 1; m_good[c] = 0; m_miss[c] = 0; end
                end
            end
        end else if (e) begin
            if (m_mode[c] == 0) begin m_mode[c] = 1; m_good[c] = 0; m_miss[c] = 0; end
            else if (m_mode[c] == 3) begin m_pdur[c] = s; m_mode[c] = m_from[c] ? 2 : 1; end
        end else if (m_mode[c] == 3) begin
            m_pdur[c] = s;
        end else if ((m_mode[c] == 1 || m_mode[c] == 2) && s > int'(pto)) begin
            if (pausable[c]) begin m_from[c] = (m_mode[c] == 2); m_mode[c] = 3; end
            else begin m_mode[c] = 4; m_stall[c] = 1; end
        end
        m_since[c] = e ? 1 : (s < CMAX ? s + 1 : s);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) for (int c = 0; c < CH; c++) mreset(c);
        else        for (int c = 0; c < CH; c++) step(c);
    end

    task automatic cmp(input string name, input int c, input longint act, input longint want);
        checks++;
        if (act != want) begin
            errors++;
            if (nprint < 40) begin
                nprint++;
                $display("FAIL %s ch%0d @%0t: got %0d expected %0d", name, c, $time, act, want);
            end
        end
    endtask

    always @(negedge clk) begin
        for (int c = 0; c < CH; c++) begin
            cmp("locked", c, locked[c], m_mode[c] == 2);
            cmp("pause_active", c, pact[c], m_mode[c] == 3);
            cmp("pause_duration", c, pdur[c], m_pdur[c]);
            cmp("period", c, period[c], m_period[c]);
            cmp("over_viol", c, ov[c], m_over[c]);
            cmp("under_viol", c, un[c], m_under[c]);
            cmp("stall_fault", c, stall[c], m_stall[c]);
        end
    end

    task automatic chk(input string name, input longint act, input longint want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic gap(input logic [CH-1:0] m, input int g);
        edg = '0;
        repeat (g - 1) tick();
        edg = m;
        tick();
        edg = '0;
    endtask

    task automatic run(input int n, input int p0, input int p1, input int p2, input int p3);
        int per[CH];
        per = '{p0, p1, p2, p3};
        for (int t = 0; t < n; t++) begin
            for (int c = 0; c < CH; c++) edg[c] = (per[c] != 0) && (t % per[c] == 0);
            tick();
        end
        edg = '0;
    endtask

    initial begin
        en = '0; clr = '0; edg = '0; pausable = 4'b0101;
        exp_p = 16'd10; tol = 16'd1; pto = 16'd40;
        repeat (2) tick();
        chk("reset_locked", locked, 0);
        chk("reset_period", period, 0);
        chk("reset_stall", stall, 0);
        rst_n = 1'b1;
        en = '1;
        tick();

        // Lock: 8 good periods after the unmeasured first edge
        run(80, 10, 10, 10, 10);
        chk("pre_lock", locked, 0);
        edg = '1; tick(); edg = '0;
        chk("lock_rise", locked, 4'hF);
        chk("lock_period", period[0], 10);

        gap('1, 11);
        gap('1, 9);
        chk("tol_keep_lock", locked, 4'hF);
        chk("tol_period9", period[0], 9);
        gap('1, 12);
        chk("over_first", ov, 4'hF);
        chk("over_lock_held", locked, 4'hF);
        gap('1, 12);
        chk("over_second_unlock", locked, 0);
        gap('1, 8);
        chk("under_pulse", un, 4'hF);
        repeat (7) gap('1, 10);
        chk("relock_pending", locked, 0);
        gap('1, 10);
        chk("relock", locked, 4'hF);

        // Stall: ch0/ch2 pausable, ch1/ch3 fault
        edg = '0;
        repeat (40) tick();
        chk("no_pause_at_40", pact, 0);
        tick();
        chk("pause_at_41", pact, 4'b0101);
        chk("stall_at_41", stall, 4'b1010);
        chk("locked_while_paused", locked, 0);
        repeat (58) tick();
        edg = '1; tick(); edg = '0;
        chk("pause_dur_100", pdur[0], 100);
        chk("pause_exit_locked", locked, 4'b0101);
        chk("pause_exit_no_viol", ov, 0);
        chk("pause_period_kept", period[0], 10);
        gap('1, 10);
        gap('1, 10);
        chk("stall_sticky", stall, 4'b1010);

        // clear_i wins over a simultaneous edge on ch1
        edg = '0;
        repeat (9) tick();
        edg = '1; clr = 4'b0010; tick(); edg = '0; clr = '0;
        chk("clear_stall", stall, 4'b1000);
        chk("clear_period", period[1], 0);
        gap('1, 10);

        // Edge exactly at cnt=41 beats the timeout
        gap('1, 41);
        chk("edge_beats_timeout", pact, 0);
        chk("edge41_over", ov, 4'b0111);
        chk("edge41_lock_held", locked, 4'b0101);

        // Isolation: distinct rates per channel
        en = '0; tick(); en = '1;
        run(200, 10, 13, 10, 7);
        chk("iso_locked", locked, 4'b0101);
        chk("iso_period13", period[1], 13);
        chk("iso_period7", period[3], 7);

        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_locked", locked, 0);
        chk("async_rst_period", period, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        chk("post_rst_locked", locked, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
